// File: rtl/led_display_pkg.sv
// Shared types and default geometry for the HUB75 row-scan controller.
`timescale 1ns/1ps
package led_display_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend,
        StWaitBusy,
        StWaitDone,
        StLatch,
        StHold
    } scan_state_t;

    typedef logic [23:0] pixel_t;

    localparam int unsigned DEFAULT_COLS         = 64;
    localparam int unsigned DEFAULT_ROWS         = 16;
    localparam int unsigned DEFAULT_LATCH_CYCLES = 2;
    localparam int unsigned DEFAULT_HOLD_CYCLES  = 256;

    // Bit width able to index n items; never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_display_scan_timer.sv
// Loadable down-counter with zero flag; times both the latch pulse and the row-lit window.
`timescale 1ns/1ps
module led_display_scan_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/led_display_scan_ctrl.sv
// Row-scan scheduler for a HUB75 panel: fetches pixel pairs, feeds the PHY, latches and lights rows.
// Optional macro LED_SCAN_DIM_EN adds brightness_in for PWM dimming of the row-lit window.
`timescale 1ns/1ps
module led_display_scan_ctrl
    import led_display_pkg::*;
#(
    parameter int unsigned COLS         = DEFAULT_COLS,
    parameter int unsigned ROWS         = DEFAULT_ROWS,
    parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    parameter int unsigned HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
    localparam int unsigned ADDR_W      = width_of(COLS * ROWS),
    localparam int unsigned ROW_W       = width_of(ROWS),
    localparam int unsigned COL_W       = width_of(COLS)
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              enable_in,
`ifdef LED_SCAN_DIM_EN
    input  logic [7:0]        brightness_in,
`endif
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              mem_rd_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  pixel_t            mem_top_data_in,
    input  pixel_t            mem_bot_data_in,
    output logic              phy_en_out,
    input  logic              phy_ready_in,
    output pixel_t            pixel_top_out,
    output pixel_t            pixel_bot_out,
    output logic [ROW_W-1:0]  row_addr_out,
    output logic              latch_out,
    output logic              blank_out
);

    localparam int unsigned TMR_W =
        width_of((HOLD_CYCLES > LATCH_CYCLES) ? HOLD_CYCLES : LATCH_CYCLES);

    scan_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_addr_q;
    pixel_t           pix_top_q, pix_bot_q;

    logic             latch_entry;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_zero;

    led_display_scan_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk_in),
        .n_reset    (n_reset_in),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            row_addr_q <= '0;
            pix_top_q  <= '0;
            pix_bot_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (latch_entry) begin
                row_addr_q <= row_q;
            end
            // Memory data is valid during CAPTURE, one cycle after the read strobe.
            if (state_q == StCapture) begin
                pix_top_q <= mem_top_data_in;
                pix_bot_q <= mem_bot_data_in;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        tmr_load       = 1'b0;
        tmr_value      = '0;
        latch_entry    = 1'b0;
        mem_rd_out     = 1'b0;
        phy_en_out     = 1'b0;
        latch_out      = 1'b0;
        frame_done_out = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_in) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_rd_out = 1'b1;
                state_d    = StCapture;
            end
            StCapture: begin
                state_d = StSend;
            end
            StSend: begin
                if (phy_ready_in) begin
                    phy_en_out = 1'b1;
                    state_d    = StWaitBusy;
                end
            end
            StWaitBusy: begin
                // PHY still shows ready this cycle; it drops ready only after capturing.
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (phy_ready_in) begin
                    if (!enable_in) begin
                        state_d = StIdle;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == COL_W'(COLS - 1)) begin
                        state_d     = StLatch;
                        col_d       = '0;
                        latch_entry = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_value   = TMR_W'(LATCH_CYCLES - 1);
                    end else begin
                        state_d = StFetch;
                        col_d   = col_q + COL_W'(1);
                    end
                end
            end
            StLatch: begin
                latch_out = 1'b1;
                if (tmr_zero) begin
                    state_d   = StHold;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(HOLD_CYCLES - 1);
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d          = '0;
                        frame_done_out = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    state_d = enable_in ? StFetch : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef LED_SCAN_DIM_EN
    logic [7:0]  brightness_q;
    int unsigned hold_elapsed;
    int unsigned dim_thresh;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            brightness_q <= '0;
        end else if (latch_entry) begin
            brightness_q <= brightness_in;
        end
    end

    always_comb begin
        hold_elapsed = HOLD_CYCLES - 1 - 32'(tmr_count);
        dim_thresh   = (32'(brightness_q) * HOLD_CYCLES) >> 8;
        blank_out    = 1'b1;
        if (state_q == StHold) begin
            blank_out = (hold_elapsed >= dim_thresh);
        end
    end
`else
    logic unused_tmr_count;
    assign unused_tmr_count = ^tmr_count;

    always_comb begin
        blank_out = (state_q != StHold);
    end
`endif

    assign busy_out      = (state_q != StIdle);
    assign mem_addr_out  = (state_q == StFetch) ?
                           ADDR_W'(32'(row_q) * COLS + 32'(col_q)) : '0;
    assign pixel_top_out = pix_top_q;
    assign pixel_bot_out = pix_bot_q;
    assign row_addr_out  = row_addr_q;

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Directed bench for led_display_scan_ctrl with a small PHY and frame-memory model.
`timescale 1ns/1ps
module tb_led_display_scan_ctrl;

    localparam int unsigned COLS         = 4;
    localparam int unsigned ROWS         = 2;
    localparam int unsigned LATCH_CYCLES = 2;
    localparam int unsigned HOLD_CYCLES  = 8;
    localparam int unsigned ADDR_W       = 3;
    localparam int unsigned ROW_W        = 1;
`ifdef LED_SCAN_DIM_EN
    localparam int unsigned LIT_CYCLES   = 4;
`else
    localparam int unsigned LIT_CYCLES   = 8;
`endif

    logic              clk_in = 1'b0;
    logic              n_reset_in;
    logic              enable_in;
    logic [7:0]        brightness_in;
    logic              busy_out;
    logic              frame_done_out;
    logic              mem_rd_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [23:0]       mem_top_data_in = '0;
    logic [23:0]       mem_bot_data_in = '0;
    logic              phy_en_out;
    logic              phy_ready_in = 1'b1;
    logic [23:0]       pixel_top_out;
    logic [23:0]       pixel_bot_out;
    logic [ROW_W-1:0]  row_addr_out;
    logic              latch_out;
    logic              blank_out;

    led_display_scan_ctrl #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .LATCH_CYCLES (LATCH_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clk_in          (clk_in),
        .n_reset_in      (n_reset_in),
        .enable_in       (enable_in),
`ifdef LED_SCAN_DIM_EN
        .brightness_in   (brightness_in),
`endif
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .mem_rd_out      (mem_rd_out),
        .mem_addr_out    (mem_addr_out),
        .mem_top_data_in (mem_top_data_in),
        .mem_bot_data_in (mem_bot_data_in),
        .phy_en_out      (phy_en_out),
        .phy_ready_in    (phy_ready_in),
        .pixel_top_out   (pixel_top_out),
        .pixel_bot_out   (pixel_bot_out),
        .row_addr_out    (row_addr_out),
        .latch_out       (latch_out),
        .blank_out       (blank_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // PHY/memory model and monitors, all evaluated on the falling edge.
    int          phy_len = 3;
    int          phy_cnt = 0;
    bit          phy_pend = 1'b0;
    bit          phy_hold = 1'b0;
    int          rd_cnt = 0, en_cnt = 0, fd_cnt = 0;
    logic [2:0]  addr_q[$];
    logic [23:0] pix_log[$];
    int          row_log[$];
    bit          pix_win = 1'b0;
    int          pix_win_cycles = 0, pix_bad = 0;
    int          blank_run = 0, blank_last_run = 0, blank_low_total = 0;
    int          latch_run = 0, latch_last_run = 0;
    logic        latch_prev = 1'b0;
    logic        en_now;

    always @(negedge clk_in) begin
        en_now = phy_en_out;
        if (!n_reset_in) begin
            phy_cnt  = 0;
            phy_pend = 1'b0;
        end else begin
            if (mem_rd_out) begin
                rd_cnt++;
                addr_q.push_back(mem_addr_out);
                if (mem_addr_out == 3'd2) begin
                    mem_top_data_in = 24'hA5_0F_33;
                    mem_bot_data_in = 24'h00_FF_01;
                end else begin
                    mem_top_data_in = 24'h100000 + 24'(mem_addr_out);
                    mem_bot_data_in = 24'h200000 + 24'(mem_addr_out);
                end
            end
            if (en_now) begin
                en_cnt++;
                pix_log.push_back(pixel_top_out);
                if (en_cnt == 3) pix_win = 1'b1;
            end
            if (pix_win) begin
                pix_win_cycles++;
                if (pixel_top_out !== 24'hA5_0F_33 || pixel_bot_out !== 24'h00_FF_01) pix_bad++;
            end
            if (frame_done_out) fd_cnt++;
            if (!blank_out) begin
                blank_run++;
                blank_low_total++;
            end else if (blank_run > 0) begin
                blank_last_run = blank_run;
                blank_run = 0;
            end
            if (latch_out) begin
                latch_run++;
            end else if (latch_run > 0) begin
                latch_last_run = latch_run;
                latch_run = 0;
            end
            if (latch_out && !latch_prev) row_log.push_back(int'(row_addr_out));
            latch_prev = latch_out;
            if (phy_cnt > 0) begin
                phy_cnt--;
                if (phy_cnt == 0) pix_win = 1'b0;
            end
            if (phy_pend) phy_cnt = phy_len;
            phy_pend = en_now;
        end
        phy_ready_in = (phy_cnt == 0) && !phy_hold;
    end

    int t;
    int rd0, en0, n0, lo0, fd0;

    initial begin
        n_reset_in    = 1'b0;
        enable_in     = 1'b0;
        brightness_in = 8'h80;
        repeat (3) tick();
        n_reset_in = 1'b1;
        repeat (20) tick();

        check_eq("idle_blank", blank_out, 1);
        check_eq("idle_busy", busy_out, 0);
        check_eq("idle_mem_rd", rd_cnt, 0);
        check_eq("idle_mem_addr", mem_addr_out, 0);
        check_eq("idle_phy_en", phy_en_out, 0);
        check_eq("idle_latch", latch_out, 0);
        check_eq("idle_frame_done", frame_done_out, 0);
        check_eq("idle_row_addr", row_addr_out, 0);
        check_eq("idle_pixel_top", pixel_top_out, 0);

        // Full frame.
        enable_in = 1'b1;
        t = 0;
        while (fd_cnt < 1 && t < 400) begin tick(); t++; end
        check_eq("frame1_done", fd_cnt, 1);
        check_eq("frame1_rd_count", rd_cnt, 8);
        check_eq("frame1_en_count", en_cnt, 8);
        check_eq("frame1_addr_count", addr_q.size(), 8);
        for (int i = 0; i < 8 && i < addr_q.size(); i++) begin
            check_eq($sformatf("frame1_addr%0d", i), addr_q[i], i);
        end
        check_eq("row_latch_count", row_log.size(), 2);
        if (row_log.size() >= 2) begin
            check_eq("row_addr_first", row_log[0], 0);
            check_eq("row_addr_second", row_log[1], 1);
        end
        check_eq("latch_width", latch_last_run, LATCH_CYCLES);
        check_eq("row_lit_cycles", blank_last_run, LIT_CYCLES);
        check_eq("pixel_hold_window", pix_win_cycles, 5);
        check_eq("pixel_hold_errors", pix_bad, 0);
        if (pix_log.size() >= 4) begin
            check_eq("pixel_addr0", pix_log[0], 24'h100000);
            check_eq("pixel_addr3", pix_log[3], 24'h100003);
        end

        t = 0;
        while (rd_cnt < 9 && t < 50) begin tick(); t++; end
        check_eq("wrap_rd", rd_cnt, 9);
        if (addr_q.size() >= 9) check_eq("wrap_addr", addr_q[8], 0);
        check_eq("frame_done_single", fd_cnt, 1);

        // PHY stalls with ready low for 50 cycles.
        t = 0;
        while (en_cnt < 9 && t < 50) begin tick(); t++; end
        phy_hold = 1'b1;
        rd0 = rd_cnt;
        en0 = en_cnt;
        repeat (50) tick();
        check_eq("stall_no_en", en_cnt - en0, 0);
        check_eq("stall_no_rd", rd_cnt - rd0, 0);
        check_eq("stall_busy", busy_out, 1);
        check_eq("stall_blank", blank_out, 1);
        phy_hold = 1'b0;
        t = 0;
        while (en_cnt < 10 && t < 20) begin tick(); t++; end
        check_eq("resume_en", en_cnt - en0, 1);
        check_eq("resume_rd", rd_cnt - rd0, 1);

        // Drop enable while column 1 is being transferred.
        enable_in = 1'b0;
        rd0 = rd_cnt;
        repeat (2) tick();
        check_eq("drain_busy", busy_out, 1);
        repeat (8) tick();
        check_eq("drop_busy", busy_out, 0);
        check_eq("drop_blank", blank_out, 1);
        check_eq("drop_no_rd", rd_cnt - rd0, 0);
        check_eq("drop_no_en", en_cnt, 10);
        check_eq("drop_phy_ready", phy_ready_in, 1);
        n0 = addr_q.size();
        enable_in = 1'b1;
        t = 0;
        while (addr_q.size() <= n0 && t < 20) begin tick(); t++; end
        check_eq("restart_rd", addr_q.size(), n0 + 1);
        if (addr_q.size() > n0) check_eq("restart_addr", addr_q[n0], 0);

        // Asynchronous reset in the middle of HOLD.
        t = 0;
        while (blank_out !== 1'b0 && t < 200) begin tick(); t++; end
        check_eq("reach_hold", blank_out, 0);
        #2;
        n_reset_in = 1'b0;
        #1;
        check_eq("async_blank", blank_out, 1);
        check_eq("async_latch", latch_out, 0);
        check_eq("async_busy", busy_out, 0);
        check_eq("async_row_addr", row_addr_out, 0);
        enable_in = 1'b0;
        tick();
        n_reset_in = 1'b1;
        tick();

`ifdef LED_SCAN_DIM_EN
        // Zero brightness keeps every row dark.
        brightness_in = 8'h00;
        lo0 = blank_low_total;
        fd0 = fd_cnt;
        enable_in = 1'b1;
        t = 0;
        while (fd_cnt <= fd0 && t < 400) begin tick(); t++; end
        check_eq("dim0_frame", fd_cnt - fd0, 1);
        check_eq("dim0_never_lit", blank_low_total - lo0, 0);
        enable_in = 1'b0;
`else
        lo0 = 0;
        fd0 = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
